// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into an ALU operation
// and two operands. Results are registered behind a valid/ready handshake
// with a two-entry skid buffer. in_ready is a pure register, so it has no
// combinational path from out_ready.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_op,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  // funct3 -> ALU op for the base (funct7 = 0) encodings of OP / OP-IMM.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'b000:  r = ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_sh;
  logic [XLEN-1:0] imm_u;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};

  logic            dec_legal;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  entry_t          dec_entry;

  // Decode the incoming instruction into a raw operation/operands and a legality flag.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_op1   = {XLEN{1'b0}};
    dec_op2   = {XLEN{1'b0}};
    case (opcode)
      OPC_OP: begin
        dec_op1 = in_rs1_data;
        dec_op2 = in_rs2_data;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_op    = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SRA;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        dec_op1 = in_rs1_data;
        dec_op2 = imm_i;
        dec_op  = base_op(funct3);
        if (funct3 == 3'b001) begin
          dec_op2   = imm_sh;
          dec_legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec_op2   = imm_sh;
          dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          dec_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op2   = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op1   = in_pc;
        dec_op2   = imm_u;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Build the entry; illegal entries carry zeroed operation fields.
  always_comb begin
    dec_entry.rd      = in_instr[11:7];
    dec_entry.pc      = in_pc;
    dec_entry.illegal = ~dec_legal;
    dec_entry.wb_en   = dec_legal && (in_instr[11:7] != 5'd0);
    if (dec_legal) begin
      dec_entry.op  = dec_op;
      dec_entry.op1 = dec_op1;
      dec_entry.op2 = dec_op2;
    end else begin
      dec_entry.op  = ALU_ADD;
      dec_entry.op1 = {XLEN{1'b0}};
      dec_entry.op2 = {XLEN{1'b0}};
    end
  end

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   xfer;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid && in_ready;
  assign xfer     = main_valid && out_ready;

  // Two-entry skid buffer: main feeds the outputs, skid absorbs one entry of backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (xfer) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_q     <= dec_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec_entry;
        skid_valid <= 1'b1;
      end
    end else begin
      main_valid <= main_valid;
    end
  end

  assign out_valid   = main_valid;
  assign out_op      = main_q.op;
  assign out_op1     = main_q.op1;
  assign out_op2     = main_q.op2;
  assign out_rd      = main_q.rd;
  assign out_wb_en   = main_q.wb_en;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the ALU's inputs: 4-bit operation code, op1 and op2.
- Accepts one RV32I instruction per cycle with its PC and register-file read data.
- Decodes OP, OP-IMM, LUI and AUIPC into ALU operation and operands; flags all other opcodes as illegal.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the ALU/execute stage can stall without a combinational ready path upstream.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; drops all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
in_instr  input  32  instruction word
in_pc  input  32  instruction address
in_rs1_data  input  32  register-file value for instr[19:15]
in_rs2_data  input  32  register-file value for instr[24:20]
out_valid  output  1  issued entry valid
out_ready  input  1  ALU/execute stage accepts entry
out_op  output  4  ALU operation code
out_op1  output  32  ALU operand 1
out_op2  output  32  ALU operand 2
out_rd  output  5  destination register (instr[11:7])
out_wb_en  output  1  write-back enable
out_illegal  output  1  instruction not decodable by this stage
out_pc  output  32  PC of the issued entry

Behaviour:
- ALU operation encoding:
  - 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
  - 10–15 are never emitted.
- OP (opcode 0110011):
  - op1 = rs1_data, op2 = rs2_data.
  - funct7 0000000: funct3 maps 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - funct7 0100000: legal only with funct3 000 (sub) or 101 (sra).
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (opcode 0010011):
  - op1 = rs1_data, op2 = sign-extended instr[31:20].
  - Operation mapping is the same as OP, except funct3 000 is always add (no subi).
  - Shifts (funct3 001/101): op2 = zero-extended instr[24:20].
  - slli requires funct7 0000000.
  - srli/srai require funct7 0000000/0100000 respectively; anything else is illegal.
- LUI (0110111): op = add, op1 = 0, op2 = {instr[31:12], 12'b0}.
- AUIPC (0010111): op = add, op1 = pc, op2 = {instr[31:12], 12'b0}.
- Illegal entries:
  - Any other opcode, or an illegal funct combination, is still issued.
  - Fields: out_illegal=1, op=0, op1=0, op2=0, wb_en=0; rd and pc passed through.
- out_wb_en = legal && rd != 0.
- Latency and throughput:
  - Exactly 1 cycle: an entry accepted at edge N is presented with out_valid=1 after edge N.
  - Sustains 1 entry/cycle when out_ready is held high.
- Handshake:
  - Transfer occurs on an edge where valid && ready.
  - While out_valid=1 and out_ready=0, all out_* fields are held stable.
  - out_valid never drops without a transfer or a flush.
- Skid buffer:
  - Two registered entries: main (drives outputs) and skid.
  - in_ready = !skid_valid, registered; no combinational path from out_ready.
  - If an input is accepted while main is occupied and not transferring, it goes to skid.
  - When main transfers, skid (if valid) moves to main; any simultaneously accepted input goes to main if skid was empty, otherwise to skid.
  - Order is strictly FIFO.
- Full/empty: skid_valid=1 implies main_valid=1. Full ⇒ in_ready=0; an in_valid presented while in_ready=0 is ignored.
- flush:
  - At the next edge, main_valid = skid_valid = 0 and in_ready = 1.
  - Any input presented in the same cycle is discarded.
  - flush overrides a simultaneous transfer; the downstream stage must also ignore that cycle.
- Reset:
  - rst_n low asynchronously clears main_valid and skid_valid.
  - Outputs during reset: out_valid=0, in_ready=1, out_op=0, out_op1=0, out_op2=0, out_rd=0, out_wb_en=0, out_illegal=0, out_pc=0.
  - Reset mid-transfer loses all buffered entries.
  - First acceptance is possible on the first edge after rst_n deasserts.

Test Plan:
- ADD: instr 0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op=0, op1=5, op2=7, rd=3, wb_en=1.
- SUB and SRAI back-to-back:
  - 0x402081B3 → op=1.
  - 0x40435293 with rs1=0x80000000 → op=7, op2=4, rd=5.
  - Both issued on consecutive cycles.
- Immediates:
  - ADDI 0xFFF00093 → op=0, op2=0xFFFFFFFF, rd=1.
  - LUI 0x12345137 → op1=0, op2=0x12345000.
  - AUIPC 0x12345117 with pc=0x100 → op1=0x100.
- Illegal:
  - 0x00000073 (system) → out_illegal=1, wb_en=0, op1=op2=0.
  - OP with funct7=0100000, funct3=100 → illegal.
- Backpressure: stream A, B, C with out_ready=0 from cycle 1 → A held stable, B in skid, in_ready=0, C not accepted. Raise out_ready → A, B, C emerge in order, with no duplicates and no drops.
- Flush and reset:
  - With both entries full, pulse flush → out_valid=0 and in_ready=1 next cycle.
  - Repeat with rst_n pulsed low mid-cycle → outputs clear immediately without a clock edge.
